// File: rtl/box_track_ctrl.sv
// Frame-rate box tracker: qualifies per-frame detections and runs an IDLE/ACQUIRE/TRACK/LOST FSM.
// Optional macro BOX_SMOOTH_EN averages the tracked box with each new detection while in TRACK.
module box_track_ctrl #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HIGH    = 480,
    parameter int MIN_SIZE    = 4,
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic [9:0] raw_up,
    input  logic [9:0] raw_down,
    input  logic [9:0] raw_left,
    input  logic [9:0] raw_right,
    output logic       box_valid,
    output logic [9:0] box_up,
    output logic [9:0] box_down,
    output logic [9:0] box_left,
    output logic [9:0] box_right,
    output logic [9:0] center_x,
    output logic [9:0] center_y,
    output logic [1:0] track_state,
    output logic       overlay_en
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOST  = 2'd3
    } state_t;

    // A geometry wider than the 10-bit edge buses can never produce a trustworthy detection.
    localparam logic        CFG_OK  = (IMG_WIDTH <= 1024) && (IMG_HIGH <= 1024);
    localparam logic [10:0] MIN_SZ  = 11'(MIN_SIZE);
    localparam logic [31:0] ACQ_N   = 32'(ACQ_FRAMES);
    localparam logic [31:0] LOST_N  = 32'(LOST_FRAMES);

    function automatic logic [9:0] avg10(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[10:1];
    endfunction

    logic        vsync_r;
    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s, cnt_sat_s;
    logic [4:0]  cnt_inc_s;
    logic        frame_end_s, det_s;
    logic [10:0] width_s, height_s;
    logic [9:0]  box_up_r, box_down_r, box_left_r, box_right_r;
    logic [9:0]  box_up_nxt_s, box_down_nxt_s, box_left_nxt_s, box_right_nxt_s;
    logic [9:0]  center_x_r, center_y_r;
    logic        box_valid_r, overlay_en_r;
    logic [10:0] cx_sum_s, cy_sum_s;

    assign frame_end_s = vsync_r & ~per_frame_vsync;
    assign cnt_inc_s   = {1'b0, cnt_r} + 5'd1;
    assign cnt_sat_s   = cnt_inc_s[4] ? 4'hF : cnt_inc_s[3:0];
    assign cx_sum_s    = {1'b0, box_left_r} + {1'b0, box_right_r};
    assign cy_sum_s    = {1'b0, box_up_r} + {1'b0, box_down_r};

    // Detection qualification; extents are only meaningful once ordering is confirmed.
    always_comb begin
        width_s  = {1'b0, raw_right} - {1'b0, raw_left} + 11'd1;
        height_s = {1'b0, raw_down} - {1'b0, raw_up} + 11'd1;
        det_s    = CFG_OK && (raw_down >= raw_up) && (raw_right >= raw_left) &&
                   (width_s >= MIN_SZ) && (height_s >= MIN_SZ);
    end

    // Next-state and frame counter; only consumed on frame_end.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_sat_s;
        case (state_r)
            ST_IDLE: begin
                if (det_s) begin
                    if (ACQ_FRAMES <= 1) begin
                        state_nxt_s = ST_TRACK;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = ST_ACQ;
                        cnt_nxt_s   = 4'd1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACQ: begin
                if (det_s && ({27'd0, cnt_inc_s} >= ACQ_N)) begin
                    state_nxt_s = ST_TRACK;
                    cnt_nxt_s   = 4'd0;
                end else if (det_s) begin
                    state_nxt_s = ST_ACQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            ST_TRACK: begin
                if (det_s) begin
                    state_nxt_s = ST_TRACK;
                end else begin
                    state_nxt_s = ST_LOST;
                    cnt_nxt_s   = 4'd1;
                end
            end
            ST_LOST: begin
                if (det_s) begin
                    state_nxt_s = ST_TRACK;
                    cnt_nxt_s   = 4'd0;
                end else if ({27'd0, cnt_inc_s} >= LOST_N) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_LOST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Box edge update: load while tracking a detection, hold otherwise, clear when going idle.
    always_comb begin
        box_up_nxt_s    = box_up_r;
        box_down_nxt_s  = box_down_r;
        box_left_nxt_s  = box_left_r;
        box_right_nxt_s = box_right_r;
        if (state_nxt_s == ST_TRACK && det_s) begin
`ifdef BOX_SMOOTH_EN
            if (state_r == ST_TRACK) begin
                box_up_nxt_s    = avg10(box_up_r, raw_up);
                box_down_nxt_s  = avg10(box_down_r, raw_down);
                box_left_nxt_s  = avg10(box_left_r, raw_left);
                box_right_nxt_s = avg10(box_right_r, raw_right);
            end else begin
                box_up_nxt_s    = raw_up;
                box_down_nxt_s  = raw_down;
                box_left_nxt_s  = raw_left;
                box_right_nxt_s = raw_right;
            end
`else
            box_up_nxt_s    = raw_up;
            box_down_nxt_s  = raw_down;
            box_left_nxt_s  = raw_left;
            box_right_nxt_s = raw_right;
`endif
        end else if (state_nxt_s == ST_IDLE) begin
            box_up_nxt_s    = 10'd0;
            box_down_nxt_s  = 10'd0;
            box_left_nxt_s  = 10'd0;
            box_right_nxt_s = 10'd0;
        end else begin
            box_up_nxt_s    = box_up_r;
            box_down_nxt_s  = box_down_r;
            box_left_nxt_s  = box_left_r;
            box_right_nxt_s = box_right_r;
        end
    end

    // Frame-rate state, counter and box registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r      <= 1'b0;
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            box_up_r     <= 10'd0;
            box_down_r   <= 10'd0;
            box_left_r   <= 10'd0;
            box_right_r  <= 10'd0;
            box_valid_r  <= 1'b0;
            overlay_en_r <= 1'b0;
        end else begin
            vsync_r <= per_frame_vsync;
            if (frame_end_s) begin
                state_r      <= state_nxt_s;
                cnt_r        <= cnt_nxt_s;
                box_up_r     <= box_up_nxt_s;
                box_down_r   <= box_down_nxt_s;
                box_left_r   <= box_left_nxt_s;
                box_right_r  <= box_right_nxt_s;
                box_valid_r  <= (state_nxt_s == ST_TRACK) || (state_nxt_s == ST_LOST);
                overlay_en_r <= (state_nxt_s == ST_TRACK) || (state_nxt_s == ST_LOST);
            end
        end
    end

    // Centre trails the box registers by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            center_x_r <= 10'd0;
            center_y_r <= 10'd0;
        end else begin
            center_x_r <= cx_sum_s[10:1];
            center_y_r <= cy_sum_s[10:1];
        end
    end

    assign track_state = state_r;
    assign box_valid   = box_valid_r;
    assign overlay_en  = overlay_en_r;
    assign box_up      = box_up_r;
    assign box_down    = box_down_r;
    assign box_left    = box_left_r;
    assign box_right   = box_right_r;
    assign center_x    = center_x_r;
    assign center_y    = center_y_r;

endmodule

// File: doc/box_track_ctrl.md
BOX_TRACK_CTRL -- requirements
Module: box_track_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_HIGH, default 480, active lines per frame.
REQ-003 SHALL have parameter MIN_SIZE, default 4, minimum box width and height in pixels for a valid detection.
REQ-004 SHALL have parameter ACQ_FRAMES, default 3, consecutive detected frames needed to enter TRACK.
REQ-005 SHALL have parameter LOST_FRAMES, default 8, consecutive missed frames before returning to IDLE.
REQ-006 SHALL use one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-007 Ports SHALL be:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  frame-valid of the detection stream.
- raw_up, raw_down, raw_left, raw_right  in  10 each  raw per-frame box edges, stable from vsync falling edge until next vsync rising edge.
- box_valid  out  1  tracked box is meaningful.
- box_up, box_down, box_left, box_right  out  10 each  tracked box.
- center_x, center_y  out  10 each  tracked box centre.
- track_state  out  2  IDLE=0, ACQUIRE=1, TRACK=2, LOST=3.
- overlay_en  out  1  frame-registered enable for box drawing.

Function
REQ-008 SHALL register per_frame_vsync once; frame_end = registered high AND input low (one-cycle pulse).
REQ-009 On frame_end SHALL sample raw edges; det = (raw_down >= raw_up) AND (raw_right >= raw_left) AND (raw_right-raw_left+1 >= MIN_SIZE) AND (raw_down-raw_up+1 >= MIN_SIZE), computed at 11 bits without wrap.
REQ-010 The empty-frame reset pattern (up=479, down=0, left=639, right=0) SHALL yield det=0 by REQ-009.
REQ-011 A saturating 4-bit counter cnt SHALL count consecutive frames of the current condition; it SHALL be cleared on every state change.
REQ-012 FSM transitions SHALL be evaluated only on frame_end:
- IDLE: det -> ACQUIRE (cnt=1); else stay.
- ACQUIRE: det and cnt+1 >= ACQ_FRAMES -> TRACK; det -> cnt+1; !det -> IDLE.
- TRACK: det -> stay; !det -> LOST (cnt=1).
- LOST: det -> TRACK; !det and cnt+1 >= LOST_FRAMES -> IDLE; else cnt+1.
REQ-013 With ACQ_FRAMES <= 1, IDLE SHALL go directly to TRACK on det.
REQ-014 box_* SHALL load the sampled raw edges when the next state is TRACK with det=1, hold in LOST, and be cleared to 0 on entry to IDLE.
REQ-015 center_x = (box_left+box_right)>>1 and center_y = (box_up+box_down)>>1 SHALL use 11-bit sums and be registered one cycle after box_*.
REQ-016 box_valid SHALL be 1 exactly when track_state is TRACK or LOST; overlay_en SHALL equal box_valid.
REQ-017 Latency SHALL be: track_state, box_*, box_valid update on the cycle after frame_end; center_* one cycle later.
REQ-018 Outputs SHALL be constant between frame_end pulses.
REQ-019 A vsync glitch shorter than one clock that is not captured SHALL have no effect.

Reset
REQ-020 On rst_n low all outputs, cnt, the FSM (IDLE) and the vsync register SHALL clear to 0 immediately.
REQ-021 After reset mid-frame, the first frame_end SHALL be treated as a normal IDLE evaluation.

Configuration
REQ-022 Macro BOX_SMOOTH_EN defined: in TRACK with det, each box edge SHALL load (old+new)>>1 at 11 bits, except on entry from ACQUIRE, where it loads raw. Undefined: box edges load raw values (REQ-014).

Verification
REQ-023 Raw box (100,200,150,300) for 3 frames -> states 1,1,2; after the third frame_end, box=(100,200,150,300), center_x=225, center_y=150, box_valid=1.
REQ-024 In TRACK, empty pattern for 8 frames -> LOST for 7 frames with box held, then IDLE, box=0, box_valid=0.
REQ-025 In LOST, one detected frame -> TRACK, box = new raw values.
REQ-026 Box width 3 (left=10, right=12) -> det=0, state stays IDLE.
REQ-027 rst_n asserted in TRACK mid-frame -> all outputs 0 asynchronously; the next frame starts ACQUIRE.
REQ-028 With BOX_SMOOTH_EN, TRACK box left=100 then raw left=200 -> box_left=150.
